// File: rtl/control_multiciclo.sv
// Control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/writeback,
// handshakes memory through mem_ready with a bounded wait, and traps illegal opcodes.
module control_multiciclo #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [2:0] imm_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] estado
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        ERROR    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // The TIMEOUT-th consecutive wait cycle without mem_ready is the one that traps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       imm_q, imm_next;
    logic             illegal_q, timeout_q;
    logic             set_illegal, set_timeout, waiting;
    logic             unused_funct7_5;

    // funct7_5 is decoded by the ALU control downstream when alu_op = 2.
    assign unused_funct7_5 = funct7_5;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            cnt       <= '0;
            imm_q     <= IMM_I;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            imm_q     <= imm_next;
            illegal_q <= illegal_q | set_illegal;
            timeout_q <= timeout_q | set_timeout;
        end
    end

    // NOTE: every output is given a default before the case so no path infers a latch.
    always_comb begin
        state_next  = state;
        cnt_next    = '0;
        imm_next    = imm_q;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        waiting     = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        alu_op      = 2'd0;
        result_src  = 2'd0;

        case (state)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                if (mem_ready) begin
                    pc_write   = 1'b1;
                    ir_write   = 1'b1;
                    state_next = DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            DECODE: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_next  = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_R:              state_next = EXECR;
                    OP_I:              state_next = EXECI;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    OP_LUI:            state_next = LUI;
                    default: begin
                        state_next  = ERROR;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 2'd2;
                alu_src_b  = 2'd1;
                imm_next   = (opcode == OP_LOAD) ? IMM_I : IMM_S;
                state_next = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
                if (mem_ready) state_next = MEMWB;
                else           waiting    = 1'b1;
            end
            MEMWB: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) state_next = FETCH;
                else           waiting    = 1'b1;
            end
            EXECR: begin
                alu_src_a  = 2'd2;
                alu_op     = 2'd2;
                state_next = ALUWB;
            end
            EXECI: begin
                alu_src_a  = 2'd2;
                alu_src_b  = 2'd1;
                imm_next   = IMM_I;
                alu_op     = 2'd2;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'd2;
                alu_op    = 2'd1;
                case (funct3)
                    3'b000: begin
                        pc_write   = zero;
                        state_next = FETCH;
                    end
                    3'b001: begin
                        pc_write   = ~zero;
                        state_next = FETCH;
                    end
                    default: begin
                        state_next  = ERROR;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            JAL: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                pc_write   = 1'b1;
                state_next = ALUWB;
            end
            LUI: begin
                alu_src_a  = 2'd3;
                alu_src_b  = 2'd1;
                imm_next   = IMM_U;
                state_next = ALUWB;
            end
            ERROR: ;
            default: state_next = ERROR;
        endcase

        if (waiting) begin
            if (cnt == CNT_LAST) begin
                state_next  = ERROR;
                set_timeout = 1'b1;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end

        // Reset masks the Mealy strobes immediately, before the state register settles.
        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            adr_src    = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 2'd0;
            alu_src_b  = 2'd0;
            alu_op     = 2'd0;
            result_src = 2'd0;
        end
    end

    assign imm_sel = rst ? IMM_I : imm_next;
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign estado  = state;

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: per-instruction trace model builds expected cycle-by-cycle
// outputs from instruction class, memory wait counts and branch conditions.
module tb_control_multiciclo;

    localparam int T = 4;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [2:0] imm_sel;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       illegal, timeout;
    logic [3:0] estado;

    always #5 clk = ~clk;

    control_multiciclo #(.TIMEOUT(T), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .illegal(illegal), .timeout(timeout), .estado(estado)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, adr, mrd, mwr, rgw;
        logic [2:0] imm;
        logic [1:0] a, b, op, res;
        logic       ill, tmo;
    } obs_t;

    typedef struct {
        logic       mr;
        logic       z;
        logic [6:0] op;
        logic [2:0] f3;
        int         id;
        obs_t       e;
    } step_t;

    step_t      q[$];
    logic [2:0] m_imm;
    logic       m_ill, m_tmo;
    logic [6:0] g_op;
    logic [2:0] g_f3;
    logic       g_z;
    int         g_id;
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t mk(logic [3:0] st, logic pcw, logic irw, logic adr, logic mrd,
                                logic mwr, logic rgw, logic [1:0] a, logic [1:0] b,
                                logic [1:0] op, logic [1:0] res);
        obs_t o;
        o.st = st;  o.pcw = pcw; o.irw = irw; o.adr = adr; o.mrd = mrd; o.mwr = mwr;
        o.rgw = rgw; o.imm = m_imm; o.a = a; o.b = b; o.op = op; o.res = res;
        o.ill = m_ill; o.tmo = m_tmo;
        return o;
    endfunction

    function automatic void push(logic mr, obs_t e);
        step_t s;
        s.mr = mr; s.z = g_z; s.op = g_op; s.f3 = g_f3; s.id = g_id; s.e = e;
        q.push_back(s);
    endfunction

    function automatic void add_error(int n);
        for (int i = 0; i < n; i++) push(rb(), mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    // w wait cycles before mem_ready; T or more waits end in the timeout trap.
    function automatic void add_wait(int w, obs_t wait_o, obs_t done_o, output bit ok);
        int n = (w >= T) ? T : w;
        for (int i = 0; i < n; i++) push(1'b0, wait_o);
        if (w >= T) begin
            m_tmo = 1'b1;
            add_error(2);
            ok = 1'b0;
        end else begin
            push(1'b1, done_o);
            ok = 1'b1;
        end
    endfunction

    function automatic void alu_wb();
        push(rb(), mk(8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    endfunction

    function automatic void gen(logic [6:0] op, logic [2:0] f3, logic z, int wf, int wm);
        bit   ok;
        logic pcw;
        g_id++; g_op = op; g_f3 = f3; g_z = z;
        add_wait(wf, mk(0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 2), mk(0, 1, 1, 0, 1, 0, 0, 0, 2, 0, 2), ok);
        if (!ok) return;
        m_imm = (op == OP_JAL) ? 3'd4 : 3'd2;
        push(rb(), mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        case (op)
            OP_LD, OP_ST: begin
                m_imm = (op == OP_LD) ? 3'd0 : 3'd1;
                push(rb(), mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
                if (op == OP_LD) begin
                    add_wait(wm, mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0),
                             mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), ok);
                    if (ok) push(rb(), mk(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
                end else begin
                    add_wait(wm, mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0),
                             mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), ok);
                end
            end
            OP_R: begin
                push(rb(), mk(6, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0));
                alu_wb();
            end
            OP_I: begin
                m_imm = 3'd0;
                push(rb(), mk(7, 0, 0, 0, 0, 0, 0, 2, 1, 2, 0));
                alu_wb();
            end
            OP_BR: begin
                if (f3 == 3'b000 || f3 == 3'b001) begin
                    pcw = (f3 == 3'b000) ? z : !z;
                    push(rb(), mk(9, pcw, 0, 0, 0, 0, 0, 2, 0, 1, 0));
                end else begin
                    push(rb(), mk(9, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
                    m_ill = 1'b1;
                    add_error(2);
                end
            end
            OP_JAL: begin
                push(rb(), mk(10, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
                alu_wb();
            end
            OP_LUI: begin
                m_imm = 3'd3;
                push(rb(), mk(11, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
                alu_wb();
            end
            default: begin
                m_ill = 1'b1;
                add_error(2);
            end
        endcase
    endfunction

    task automatic check_obs(int id, obs_t exp);
        obs_t got;
        got.st = estado; got.pcw = pc_write; got.irw = ir_write; got.adr = adr_src;
        got.mrd = mem_read; got.mwr = mem_write; got.rgw = reg_write; got.imm = imm_sel;
        got.a = alu_src_a; got.b = alu_src_b; got.op = alu_op; got.res = result_src;
        got.ill = illegal; got.tmo = timeout;
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL ctrl_outputs ins=%0d observed=%h (state %0d) expected=%h (state %0d)",
                   id, got, got.st, exp, exp.st);
        end
        n_checks++;
        assert (!(mem_read === 1'b1 && mem_write === 1'b1)) else begin
            n_fail++;
            $error("FAIL rd_wr_exclusive ins=%0d observed mem_read=%b mem_write=%b expected not both 1",
                   id, mem_read, mem_write);
        end
    endtask

    task automatic run_trace(int max_steps);
        step_t s;
        int    n = 0;
        while (q.size() > 0 && n < max_steps) begin
            s = q.pop_front();
            mem_ready = s.mr; zero = s.z; opcode = s.op; funct3 = s.f3;
            funct7_5  = rb();
            @(negedge clk);
            check_obs(s.id, s.e);
            @(posedge clk);
            #1;
            n++;
        end
        q.delete();
    endtask

    // Entered at posedge+1; checks all outputs are masked while rst is high.
    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = OP_JAL;
        #1;
        check_obs(-1, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_imm = 3'd0; m_ill = 1'b0; m_tmo = 1'b0;
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 5) == 0) ? $urandom_range(1, T) : 0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        m_imm = 3'd0; m_ill = 1'b0; m_tmo = 1'b0; g_id = 0;
        #1;
        check_obs(0, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // R-type with immediate memory, then load with three-cycle memory stall
        gen(OP_R, 3'b000, 1'b0, 0, 0);
        run_trace(1000);
        gen(OP_LD, 3'b010, 1'b0, 0, 3);
        run_trace(1000);

        // beq taken, bne not taken, then unsupported branch funct3
        gen(OP_BR, 3'b000, 1'b1, 0, 0);
        gen(OP_BR, 3'b001, 1'b1, 0, 0);
        gen(OP_BR, 3'b001, 1'b0, 0, 0);
        run_trace(1000);
        gen(OP_BR, 3'b100, 1'b0, 0, 0);
        run_trace(1000);
        do_reset();

        // lui, jal, I-type, store
        gen(OP_LUI, 3'b000, 1'b0, 0, 0);
        gen(OP_JAL, 3'b000, 1'b0, 0, 0);
        gen(OP_I, 3'b000, 1'b0, 1, 0);
        gen(OP_ST, 3'b010, 1'b0, 0, 2);
        run_trace(1000);

        // fetch timeout on the T-th wait, then mem_ready arriving exactly on that cycle
        gen(OP_R, 3'b000, 1'b0, T, 0);
        run_trace(1000);
        do_reset();
        gen(OP_R, 3'b000, 1'b0, T - 1, 0);
        run_trace(1000);

        // load timeout in MEMREAD, store timeout in MEMWRITE
        gen(OP_LD, 3'b010, 1'b0, 0, T);
        run_trace(1000);
        do_reset();
        gen(OP_ST, 3'b010, 1'b0, 0, T);
        run_trace(1000);
        do_reset();

        // unknown opcode
        gen(7'b1100111, 3'b000, 1'b0, 0, 0);
        run_trace(1000);
        do_reset();

        // asynchronous reset in the middle of a MEMWRITE stall
        gen(OP_ST, 3'b010, 1'b0, 0, 3);
        run_trace(4);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        assert (mem_write === 1'b1 && estado === 4'd5) else begin
            n_fail++;
            $error("FAIL memwrite_before_reset observed mem_write=%b estado=%0d expected 1 and 5",
                   mem_write, estado);
        end
        do_reset();

        // randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 7))
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LD;
                3: op = OP_ST;
                4: op = OP_BR;
                5: op = OP_JAL;
                6: op = OP_LUI;
                default: op = ($urandom_range(0, 1) == 0) ? 7'($urandom) : OP_R;
            endcase
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
            gen(op, f3, rb(), rand_wait(), rand_wait());
            run_trace(1000);
            if (m_ill || m_tmo) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
